// File: rtl/byte_striping_if.sv
// Byte-stream and two-lane striped bus for the transmit-side striper.
// The master drives the input stream; the slave (the striper) drives the lanes and f_phase.
interface byte_striping_if #(
    parameter int BUS_WIDTH = 8
);
    logic [BUS_WIDTH-1:0] data_in;
    logic                 valid_in;
    logic [BUS_WIDTH-1:0] data_stripe_0;
    logic                 valid_stripe_0;
    logic [BUS_WIDTH-1:0] data_stripe_1;
    logic                 valid_stripe_1;
    logic                 f_phase;

    modport master (
        output data_in, valid_in,
        input  data_stripe_0, valid_stripe_0, data_stripe_1, valid_stripe_1, f_phase
    );

    modport slave (
        input  data_in, valid_in,
        output data_stripe_0, valid_stripe_0, data_stripe_1, valid_stripe_1, f_phase
    );
endinterface

// File: rtl/byte_striping.sv
// Transmit byte striper: 2f-rate byte stream alternated onto two lanes that update once per f period.
// The f-rate window is generated locally from a phase toggle, so everything runs on clk_2f.
module byte_striping #(
    parameter int BUS_WIDTH = 8
) (
    input logic            clk_2f,
    input logic            rst,
    byte_striping_if.slave bus
);
    logic                 f_phase;
    logic                 sel;
    logic [BUS_WIDTH-1:0] hold_0;
    logic [BUS_WIDTH-1:0] hold_1;
    logic                 hv_0;
    logic                 hv_1;
    logic [BUS_WIDTH-1:0] stripe_0;
    logic [BUS_WIDTH-1:0] stripe_1;
    logic                 stripe_v_0;
    logic                 stripe_v_1;

    logic                 take_0;
    logic                 take_1;
    logic                 eff_v_0;
    logic                 eff_v_1;
    logic [BUS_WIDTH-1:0] eff_d_0;
    logic [BUS_WIDTH-1:0] eff_d_1;

    // A byte arriving in the closing phase-1 cycle bypasses the holding stage.
    always_comb begin
        take_0  = bus.valid_in && !sel;
        take_1  = bus.valid_in && sel;
        eff_v_0 = take_0 || hv_0;
        eff_v_1 = take_1 || hv_1;
        eff_d_0 = take_0 ? bus.data_in : hold_0;
        eff_d_1 = take_1 ? bus.data_in : hold_1;
    end

    always_ff @(posedge clk_2f or posedge rst) begin
        if (rst) begin
            f_phase    <= 1'b0;
            sel        <= 1'b0;
            hold_0     <= '0;
            hold_1     <= '0;
            hv_0       <= 1'b0;
            hv_1       <= 1'b0;
            stripe_0   <= '0;
            stripe_1   <= '0;
            stripe_v_0 <= 1'b0;
            stripe_v_1 <= 1'b0;
        end else begin
            f_phase <= ~f_phase;
            if (bus.valid_in) begin
                sel <= ~sel;
            end
            if (f_phase) begin
                stripe_v_0 <= eff_v_0;
                stripe_v_1 <= eff_v_1;
                stripe_0   <= eff_v_0 ? eff_d_0 : '0;
                stripe_1   <= eff_v_1 ? eff_d_1 : '0;
                hv_0       <= 1'b0;
                hv_1       <= 1'b0;
            end else if (bus.valid_in) begin
                if (sel) begin
                    hold_1 <= bus.data_in;
                    hv_1   <= 1'b1;
                end else begin
                    hold_0 <= bus.data_in;
                    hv_0   <= 1'b1;
                end
            end
        end
    end

    assign bus.f_phase        = f_phase;
    assign bus.data_stripe_0  = stripe_0;
    assign bus.valid_stripe_0 = stripe_v_0;
    assign bus.data_stripe_1  = stripe_1;
    assign bus.valid_stripe_1 = stripe_v_1;
endmodule

// File: tb/tb_byte_striping.sv
// Self-checking bench for byte_striping: directed scenarios plus random traffic against a
// window-level model (stream index parity picks the lane, each window publishes its bytes).
module tb_byte_striping;
    logic clk_2f;
    logic rst;

    byte_striping_if #(.BUS_WIDTH(8)) bus ();

    byte_striping #(.BUS_WIDTH(8)) dut (
        .clk_2f (clk_2f),
        .rst    (rst),
        .bus    (bus.slave)
    );

    initial clk_2f = 1'b0;
    always #5 clk_2f = ~clk_2f;

    int n_pass  = 0;
    int n_total = 0;

    // Model: cycle count since reset, number of bytes accepted since reset,
    // bytes gathered in the current window per lane, and the published lanes.
    int       m_cycle;
    int       m_count;
    bit       win_v [2];
    bit [7:0] win_d [2];
    bit       pub_v [2];
    bit [7:0] pub_d [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic void model_reset();
        m_cycle = 0;
        m_count = 0;
        for (int k = 0; k < 2; k++) begin
            win_v[k] = 0; win_d[k] = 0; pub_v[k] = 0; pub_d[k] = 0;
        end
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".f_phase"}, bus.f_phase, (m_cycle % 2));
        chk({tag, ".v0"}, bus.valid_stripe_0, pub_v[0]);
        chk({tag, ".d0"}, bus.data_stripe_0, pub_d[0]);
        chk({tag, ".v1"}, bus.valid_stripe_1, pub_v[1]);
        chk({tag, ".d1"}, bus.data_stripe_1, pub_d[1]);
    endtask

    // One clk_2f cycle of input; checks every output just after the edge.
    task automatic cycle(input string tag, input bit v, input bit [7:0] d);
        bit closes_window;
        bus.valid_in = v;
        bus.data_in  = v ? d : 8'h00;
        closes_window = (m_cycle % 2) == 1;
        @(posedge clk_2f);
        if (v) begin
            win_v[m_count % 2] = 1;
            win_d[m_count % 2] = d;
            m_count++;
        end
        if (closes_window) begin
            for (int k = 0; k < 2; k++) begin
                pub_v[k] = win_v[k];
                pub_d[k] = win_v[k] ? win_d[k] : 8'h00;
                win_v[k] = 0;
            end
        end
        m_cycle++;
        #1;
        check_all(tag);
    endtask

    task automatic reset_cycles(input int n);
        bus.valid_in = 1'b1;
        bus.data_in  = 8'hFF;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("rst_async");
        for (int i = 0; i < n; i++) begin
            @(posedge clk_2f);
            #1;
            check_all("rst_hold");
        end
        rst = 1'b0;
        bus.valid_in = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;
        model_reset();
        #2;

        reset_cycles(3);
        for (int i = 0; i < 4; i++) cycle("phase_idle", 0, 8'h00);

        reset_cycles(1);
        for (int i = 1; i <= 8; i++) cycle("stream", 1, 8'(i));
        cycle("stream_tail", 0, 8'h00);
        cycle("stream_tail", 0, 8'h00);

        reset_cycles(1);
        cycle("gap", 1, 8'hA0);
        cycle("gap", 0, 8'h00);
        chk("gap_win1_d0", bus.data_stripe_0, 8'hA0);
        chk("gap_win1_v1", bus.valid_stripe_1, 1'b0);
        cycle("gap", 0, 8'h00);
        cycle("gap", 1, 8'hA1);
        chk("gap_win2_d1", bus.data_stripe_1, 8'hA1);
        chk("gap_win2_v0", bus.valid_stripe_0, 1'b0);
        cycle("gap", 1, 8'hA2);
        cycle("gap", 1, 8'hA3);
        chk("gap_win3_d0", bus.data_stripe_0, 8'hA2);
        chk("gap_win3_d1", bus.data_stripe_1, 8'hA3);

        // Idle window after odd traffic: sel must still point at lane 1 afterwards.
        cycle("idle", 1, 8'h11);
        cycle("idle", 0, 8'h00);
        cycle("idle", 0, 8'h00);
        cycle("idle", 0, 8'h00);
        chk("idle_v0", bus.valid_stripe_0, 1'b0);
        chk("idle_v1", bus.valid_stripe_1, 1'b0);
        cycle("idle", 1, 8'h22);
        cycle("idle", 0, 8'h00);
        chk("idle_sel_kept", bus.data_stripe_1, 8'h22);

        // Reset mid-window discards a held byte and re-arms lane 0.
        reset_cycles(1);
        cycle("midrst", 1, 8'h55);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("midrst_async");
        #2;
        rst = 1'b0;
        cycle("midrst", 1, 8'h66);
        cycle("midrst", 0, 8'h00);
        chk("midrst_lane0", bus.data_stripe_0, 8'h66);
        chk("midrst_no55", bus.data_stripe_1, 8'h00);

        // Phase-1 bypass with sel=1: visible one edge after sampling.
        reset_cycles(1);
        cycle("bypass", 1, 8'h77);
        cycle("bypass", 0, 8'h00);
        cycle("bypass", 0, 8'h00);
        cycle("bypass", 1, 8'h3C);
        chk("bypass_d1", bus.data_stripe_1, 8'h3C);
        chk("bypass_v1", bus.valid_stripe_1, 1'b1);
        chk("bypass_v0", bus.valid_stripe_0, 1'b0);

        reset_cycles(2);
        for (int i = 0; i < 400; i++) begin
            cycle("rand", 1'($urandom_range(0, 2) != 0), 8'($urandom));
            if ($urandom_range(0, 99) == 0) reset_cycles(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/byte_striping.md
# byte_striping

Transmit-side byte striper for the two-lane link. Takes a single byte stream at the 2f rate and distributes valid bytes alternately onto lane 0 and lane 1. Each lane updates once per f period, so the pair `data_stripe_0`/`data_stripe_1` feeds `byte_unstriping` directly. The block runs entirely on `clk_2f` and generates its own f-rate phase, so no separate `clk_f` domain crossing is needed.

## Interface
Parameters:
- `BUS_WIDTH`, default 8, byte width of input and both lanes.

Ports:
- `clk_2f`  input  1  single clock, 2f rate; all state changes on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `data_in`  input  BUS_WIDTH  input byte, sampled when `valid_in` is high.
- `valid_in`  input  1  qualifies `data_in` for the current cycle.
- `data_stripe_0`  output  BUS_WIDTH  lane 0 byte.
- `valid_stripe_0`  output  1  lane 0 valid.
- `data_stripe_1`  output  BUS_WIDTH  lane 1 byte.
- `valid_stripe_1`  output  1  lane 1 valid.
- `f_phase`  output  1  internal f-window phase; the lane outputs update on the edge that ends a cycle where `f_phase`=1.

## Operation
- **Phase register `f_phase`:**
  - Toggles every cycle; reset value 0.
  - One f window is two consecutive cycles: phase 0, then phase 1.
- **Lane pointer `sel`:**
  - Reset value 0, so the first valid byte after reset goes to lane 0.
  - Toggles only on cycles where `valid_in`=1; invalid cycles never advance it.
- **Holding stage:** one register plus one valid flag per lane (`hold_k`, `hv_k`).
  - On `valid_in`=1, `data_in` goes to `hold[sel]` and `hv[sel]` is set to 1.
- **Output load, on edges closing a phase-1 cycle:**
  - For each lane k, compute the effective byte and flag. If `valid_in` && `sel`==k in this cycle, use `data_in` with valid 1. Otherwise use `hold_k` with `hv_k`.
  - If the effective valid is 1: `data_stripe_k` ← effective byte, `valid_stripe_k` ← 1.
  - If the effective valid is 0: `data_stripe_k` ← 0, `valid_stripe_k` ← 0.
  - Clear `hv_0` and `hv_1` on the same edge.
- **Lane outputs:** registered, and held unchanged across the phase-0 edge.
- **Collision-free by construction:** a window holds at most 2 input cycles and lanes alternate, so each lane receives at most one byte per window. No overflow case exists and no error output is needed.
- **Lane-pair order:** if a window carries one byte, only that lane is valid. `sel` keeps its state into the next window, so lane assignment strictly alternates over the whole stream.
- **Reset (asynchronous, any time, including mid-window):**
  - All registers clear immediately: `f_phase`=0, `sel`=0, `hv_0`=`hv_1`=0.
  - Lane outputs go to `data_stripe_0`=`data_stripe_1`=0 and `valid_stripe_0`=`valid_stripe_1`=0.
  - Bytes held but not yet output are discarded.
  - After deassertion, the first rising edge is phase 0.

## Timing
- **Reset values:** all outputs 0, `f_phase`=0.
- **Latency from the edge that samples the byte:**
  - Byte accepted in a phase-1 cycle: visible after 1 edge.
  - Byte accepted in a phase-0 cycle: visible after 2 edges.
- **Output stability:** lane outputs change only on edges where the pre-edge `f_phase`=1, and hold for exactly 2 `clk_2f` cycles (one f period).
- **Throughput:** full rate, 1 byte/cycle in, 2 bytes per f period out, no backpressure.
- **Input timing:** `valid_in` and `data_in` must be stable before the rising edge. There is no handshake and the block never stalls.

## Test plan
- **Reset:**
  - Stimulus: assert `rst` for 3 cycles with `valid_in`=1 and `data_in`=8'hFF.
  - Required response: all outputs stay 0 and `f_phase`=0 throughout.
  - After release, `f_phase` alternates 0,1,0,1.
- **Continuous stream:**
  - Stimulus: after reset, `valid_in`=1 every cycle with bytes 8'h01..8'h08.
  - Required response: lanes present pairs (01,02), (03,04), (05,06), (07,08).
  - Each pair holds 2 cycles with both valids 1.
  - The first pair appears 2 edges after 8'h01 is sampled.
- **Gapped input:**
  - Stimulus: bytes 8'hA0 (phase 0), idle (phase 1), idle (phase 0), 8'hA1 (phase 1), then 8'hA2, 8'hA3.
  - Required response: window 1 is lane 0=A0 only, with `valid_stripe_1`=0 and `data_stripe_1`=0.
  - Window 2 is lane 1=A1 only.
  - Window 3 is lane 0=A2, lane 1=A3.
- **Idle window:**
  - Stimulus: `valid_in`=0 for a full window after traffic.
  - Required response: both valids 0 and both data 0 for that f period; `sel` is unchanged.
- **Reset mid-window:**
  - Stimulus: 8'h55 accepted in phase 0, then `rst` pulsed asynchronously before the phase-1 edge.
  - Required response: 8'h55 never appears on any lane.
  - The next valid byte goes to lane 0.
- **Phase-1 bypass:**
  - Stimulus: a single byte 8'h3C accepted in a phase-1 cycle, with `sel`=1.
  - Required response: after 1 edge, `data_stripe_1`=8'h3C and `valid_stripe_1`=1.
  - Lane 0 is invalid.
